// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared opcodes, register selects and FSM encoding for the register-transfer
// sequencer and the bench that drives it.
package reg_transfer_sequencer_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] R1       = 2'd1;
  localparam logic [1:0] R2       = 2'd2;
  localparam logic [1:0] R3       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_S = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR   = 3'd3,
    ST_WR2  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // READ ignores rd; LOAD ignores rs.
  function automatic logic cmd_illegal(input logic [1:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs);
    return ((op != OP_READ) && (rd == SEL_NONE)) ||
           ((op != OP_LOAD) && (rs == SEL_NONE));
  endfunction

endpackage

// File: rtl/RegisterFile.sv
// 3-entry register file: write on the rising edge when IS != 0, combinational read.
// Contents deliberately survive the sequencer reset.
module RegisterFile #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic [DATA_W-1:0] I,
  input  logic [1:0]        IS,
  input  logic [1:0]        QS,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] mem [0:3];

  always_ff @(posedge clock) begin
    if (IS != 2'd0) mem[IS] <= I;
  end

  assign Q = (QS == 2'd0) ? '0 : mem[QS];

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Command-driven initiator for the 3-entry RegisterFile: LOAD/MOV/SWAP/READ
// executed as short Moore-decoded multi-cycle sequences.
module reg_transfer_sequencer
  import reg_transfer_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_rd,
  input  logic [1:0]        cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] rf_i,
  output logic [1:0]        rf_is,
  output logic [1:0]        rf_qs,
  input  logic [DATA_W-1:0] rf_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        rd_q, rd_d;
  logic [1:0]        rs_q, rs_d;
  logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      rd_q      <= SEL_NONE;
      rs_q      <= SEL_NONE;
      tmp_a_q   <= '0;
      tmp_b_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      tmp_a_q   <= tmp_a_d;
      tmp_b_q   <= tmp_b_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    tmp_a_d   = tmp_a_q;
    tmp_b_d   = tmp_b_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          rd_d  = cmd_rd;
          rs_d  = cmd_rs;
          err_d = cmd_illegal(cmd_op, cmd_rd, cmd_rs);
          if (err_d) begin
            state_d = ST_DONE;
          end else if (cmd_op == OP_LOAD) begin
            tmp_a_d = cmd_imm;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_S;
          end
        end
      end
      ST_RD_S: begin
        tmp_a_d = rf_q;
        unique case (op_q)
          OP_MOV:  state_d = ST_WR;
          OP_SWAP: state_d = ST_RD_D;
          default: begin
            // READ: rf_q is the value tmp_a captures on this same edge
            rd_data_d = rf_q;
            state_d   = ST_DONE;
          end
        endcase
      end
      ST_RD_D: begin
        tmp_b_d = rf_q;
        state_d = ST_WR;
      end
      ST_WR:   state_d = (op_q == OP_SWAP) ? ST_WR2 : ST_DONE;
      ST_WR2:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    rf_qs     = SEL_NONE;
    rf_is     = SEL_NONE;
    rf_i      = '0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RD_S: rf_qs = rs_q;
      ST_RD_D: rf_qs = rd_q;
      ST_WR: begin
        rf_is = rd_q;
        rf_i  = tmp_a_q;
      end
      ST_WR2: begin
        rf_is = rs_q;
        rf_i  = tmp_b_q;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: busy = 1'b1;
    endcase
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed bench: sequencer + RegisterFile, scoreboard of expected completions
// and expected register writes.
module tb_reg_transfer_sequencer;
  import reg_transfer_sequencer_pkg::*;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op, cmd_rd, cmd_rs;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] rf_i, rf_q, rd_data;
  logic [1:0]    rf_is, rf_qs;
  logic          busy, done, err;

  always #5 clock = ~clock;

  reg_transfer_sequencer #(.DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_i(rf_i), .rf_is(rf_is), .rf_qs(rf_qs), .rf_q(rf_q),
    .busy(busy), .done(done), .err(err), .rd_data(rd_data)
  );

  RegisterFile #(.DATA_W(DW)) u_rf (
    .clock(clock), .I(rf_i), .IS(rf_is), .QS(rf_qs), .Q(rf_q)
  );

  typedef struct {
    string         tag;
    logic          err;
    logic [DW-1:0] rd_data;
    int            lat;
  } exp_t;

  typedef struct {
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } wr_t;

  exp_t          sb[$];
  wr_t           wq[$];
  logic [DW-1:0] m_rf [1:3];
  logic [DW-1:0] m_rd;
  int            nchk = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must match the next predicted write.
  always @(negedge clock) begin
    if (reset_n && rf_is != SEL_NONE) begin
      if (wq.size() == 0) begin
        chk("spurious_write_sel", {30'd0, rf_is}, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_sel", {30'd0, rf_is}, {30'd0, w.sel});
        chk("wr_data", {24'd0, rf_i}, {24'd0, w.data});
      end
    end
  end

  task automatic predict(input string tag, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [DW-1:0] imm);
    logic [DW-1:0] a, b;
    if (cmd_illegal(op, rd, rs)) begin
      sb.push_back('{tag, 1'b1, m_rd, 1});
    end else begin
      unique case (op)
        OP_LOAD: begin
          wq.push_back('{rd, imm});
          m_rf[rd] = imm;
          sb.push_back('{tag, 1'b0, m_rd, 2});
        end
        OP_MOV: begin
          a = m_rf[rs];
          wq.push_back('{rd, a});
          m_rf[rd] = a;
          sb.push_back('{tag, 1'b0, m_rd, 3});
        end
        OP_SWAP: begin
          a = m_rf[rs];
          b = m_rf[rd];
          wq.push_back('{rd, a});
          wq.push_back('{rs, b});
          m_rf[rd] = a;
          m_rf[rs] = b;
          sb.push_back('{tag, 1'b0, m_rd, 5});
        end
        default: begin
          m_rd = m_rf[rs];
          sb.push_back('{tag, 1'b0, m_rd, 2});
        end
      endcase
    end
  endtask

  // Called on a negedge; returns on the negedge of the first cycle after accept.
  task automatic drive_accept(input logic [1:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [DW-1:0] imm);
    int w;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // n0 = cycles since accept at the current negedge.
  task automatic wait_done(input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_done_timeout"}, {31'd0, done}, 32'd1);
    chk({e.tag, "_latency"}, n, e.lat);
    chk({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    chk({e.tag, "_rd_data"}, {24'd0, rd_data}, {24'd0, e.rd_data});
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [1:0] rd,
                     input logic [1:0] rs, input logic [DW-1:0] imm);
    predict(tag, op, rd, rs, imm);
    drive_accept(op, rd, rs, imm);
    wait_done(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_is"}, {30'd0, rf_is}, 32'd0);
    chk({tag, "_rf_qs"}, {30'd0, rf_qs}, 32'd0);
    chk({tag, "_rf_i"}, {24'd0, rf_i}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0;
    cmd_op = OP_LOAD; cmd_rd = SEL_NONE; cmd_rs = SEL_NONE; cmd_imm = '0;
    m_rd = '0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("por");
    reset_n = 1'b1;
    @(negedge clock);

    run("load_r1", OP_LOAD, R1, SEL_NONE, 8'hA5);
    run("read_r1", OP_READ, SEL_NONE, R1, 8'h00);

    // MOV: source select must be on rf_qs during the read cycle
    run("load_r2", OP_LOAD, R2, SEL_NONE, 8'h3C);
    predict("mov_r3_r2", OP_MOV, R3, R2, 8'h00);
    drive_accept(OP_MOV, R3, R2, 8'h00);
    chk("mov_rd_s_qs", {30'd0, rf_qs}, {30'd0, R2});
    wait_done(1);
    run("read_r3", OP_READ, SEL_NONE, R3, 8'h00);
    run("read_r2", OP_READ, SEL_NONE, R2, 8'h00);
    run("mov_same", OP_MOV, R3, R3, 8'h00);

    run("load_r1_11", OP_LOAD, R1, SEL_NONE, 8'h11);
    run("load_r2_22", OP_LOAD, R2, SEL_NONE, 8'h22);
    run("swap_r1_r2", OP_SWAP, R1, R2, 8'h00);
    run("read_r1_sw", OP_READ, SEL_NONE, R1, 8'h00);
    run("read_r2_sw", OP_READ, SEL_NONE, R2, 8'h00);

    run("err_load", OP_LOAD, SEL_NONE, R1, 8'hFF);
    run("err_mov", OP_MOV, R1, SEL_NONE, 8'h00);
    run("err_read", OP_READ, R1, SEL_NONE, 8'h00);
    run("err_swap", OP_SWAP, SEL_NONE, R2, 8'h00);

    // Command held during a SWAP must wait for IDLE, then execute
    predict("hold_swap", OP_SWAP, R3, R1, 8'h00);
    predict("held_load", OP_LOAD, R2, SEL_NONE, 8'h5E);
    drive_accept(OP_SWAP, R3, R1, 8'h00);
    cmd_op = OP_LOAD; cmd_rd = R2; cmd_rs = SEL_NONE; cmd_imm = 8'h5E;
    cmd_valid = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_no_done", {31'd0, done}, 32'd0);
      @(negedge clock);
    end
    chk("hold_done_ready", {31'd0, cmd_ready}, 32'd0);
    wait_done(5);
    drive_accept(OP_LOAD, R2, SEL_NONE, 8'h5E);
    wait_done(1);
    run("read_r2_held", OP_READ, SEL_NONE, R2, 8'h00);
    run("read_r3_held", OP_READ, SEL_NONE, R3, 8'h00);

    // Reset during WR2: R1 already written, R2 untouched
    run("load_r1_77", OP_LOAD, R1, SEL_NONE, 8'h77);
    run("load_r2_88", OP_LOAD, R2, SEL_NONE, 8'h88);
    wq.push_back('{R1, 8'h88});
    m_rf[1] = 8'h88;
    drive_accept(OP_SWAP, R1, R2, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    chk("wr2_sel", {30'd0, rf_is}, {30'd0, R2});
    reset_n = 1'b0;
    #1;
    m_rd = '0;
    chk_reset_outputs("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run("read_r1_rst", OP_READ, SEL_NONE, R1, 8'h00);
    run("read_r2_rst", OP_READ, SEL_NONE, R2, 8'h00);
    run("load_r3_post", OP_LOAD, R3, SEL_NONE, 8'h5A);
    run("read_r3_post", OP_READ, SEL_NONE, R3, 8'h00);

    @(negedge clock);
    chk("writes_left", wq.size(), 0);
    chk("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
